// File: rtl/note_playback_scheduler.sv
// note_playback_scheduler: walks note RAM records in address order and drives one
// monophonic voice from each record's start/end timestamps compared against timeUs.
module note_playback_scheduler #(
    parameter int ADDR_W  = 7,
    parameter int TIME_W  = 29,
    parameter int PITCH_W = 5,
    parameter int REC_W   = PITCH_W + 2*TIME_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startPlayback,
    input  logic               stopPlayback,
    input  logic [TIME_W-1:0]  timeUs,
    output logic               timerReset,
    output logic [ADDR_W-1:0]  memReadAddress,
    input  logic [REC_W-1:0]   memReadData,
    output logic               noteActive,
    output logic [PITCH_W-1:0] notePitch,
    output logic [ADDR_W-1:0]  noteIndex,
    output logic               busy,
    output logic               donePulse
);
    typedef enum logic [2:0] {IDLE, TRESET, FETCH, LATCH, WAITSTART, PLAYING, DONE} state_t;
    state_t state, nextState;
    logic [ADDR_W-1:0] addr, nextAddr, advAddr;
    logic [REC_W-1:0] rec;
    logic [TIME_W-1:0] memStart, memEnd, recStart, recEnd;
    logic [PITCH_W-1:0] recPitch;
    logic lastAddr;
    assign memStart = memReadData[2*TIME_W-1 -: TIME_W];
    assign memEnd = memReadData[TIME_W-1:0];
    assign recPitch = rec[REC_W-1 -: PITCH_W];
    assign recStart = rec[2*TIME_W-1 -: TIME_W];
    assign recEnd = rec[TIME_W-1:0];
    assign lastAddr = &addr;
    // The last record ends the run instead of wrapping back to address 0.
    assign advAddr = lastAddr ? '0 : addr + ADDR_W'(1);
    assign timerReset = state == TRESET;
    assign memReadAddress = addr;
    assign busy = state != IDLE && state != DONE;
    always_comb begin
        nextState = state;
        nextAddr = addr;
        case (state)
            TRESET: nextState = FETCH;
            FETCH: nextState = LATCH;
            LATCH: begin
                if (memReadData == '0) begin
                    nextState = DONE;
                    nextAddr = '0;
                end else if (memEnd <= memStart) begin
                    nextState = lastAddr ? DONE : FETCH;
                    nextAddr = advAddr;
                end else begin
                    nextState = WAITSTART;
                end
            end
            WAITSTART: nextState = timeUs >= recStart ? PLAYING : WAITSTART;
            PLAYING: begin
                if (timeUs >= recEnd) begin
                    nextState = lastAddr ? DONE : FETCH;
                    nextAddr = advAddr;
                end
            end
            default: nextState = state;
        endcase
        if (startPlayback && state != TRESET) begin
            nextState = TRESET;
            nextAddr = '0;
        end
        if (stopPlayback) begin
            nextState = IDLE;
            nextAddr = '0;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            addr <= '0;
            rec <= '0;
            noteActive <= 1'b0;
            notePitch <= '0;
            noteIndex <= '0;
            donePulse <= 1'b0;
        end else begin
            state <= nextState;
            addr <= nextAddr;
            if (state == LATCH) rec <= memReadData;
            noteActive <= nextState == PLAYING;
            donePulse <= nextState == DONE && state != DONE;
            if (state == WAITSTART && nextState == PLAYING) begin
                notePitch <= recPitch;
                noteIndex <= addr;
            end
        end
    end
endmodule

// File: tb/tb_note_playback_scheduler.sv
// tb_note_playback_scheduler: directed and randomized playback runs checked against
// a timeline model of when each note should rise, fall and when the run should end.
module tb_note_playback_scheduler;
    localparam int AW = 2;
    localparam int TW = 29;
    localparam int PW = 5;
    localparam int RW = PW + 2*TW;
    localparam int DEPTH = 1 << AW;

    logic clk = 0;
    logic reset = 1;
    logic startPlayback = 0;
    logic stopPlayback = 0;
    logic [TW-1:0] timeUs = '0;
    logic timerReset;
    logic [AW-1:0] memReadAddress;
    logic [RW-1:0] memReadData = '0;
    logic noteActive;
    logic [PW-1:0] notePitch;
    logic [AW-1:0] noteIndex;
    logic busy;
    logic donePulse;

    logic [RW-1:0] ram [DEPTH];
    int checks = 0;
    int errors = 0;

    int obsRise[$], obsFall[$], obsPitch[$], obsIdx[$], obsDone[$];
    int expRise[$], expFall[$], expPitch[$], expIdx[$];
    int expDone;
    int trCount = 0, trLong = 0, wraps = 0;
    bit prevActive = 0, prevTr = 0, seenNz = 0;

    note_playback_scheduler #(.ADDR_W(AW), .TIME_W(TW), .PITCH_W(PW)) dut (
        .clk(clk),
        .reset(reset),
        .startPlayback(startPlayback),
        .stopPlayback(stopPlayback),
        .timeUs(timeUs),
        .timerReset(timerReset),
        .memReadAddress(memReadAddress),
        .memReadData(memReadData),
        .noteActive(noteActive),
        .notePitch(notePitch),
        .noteIndex(noteIndex),
        .busy(busy),
        .donePulse(donePulse)
    );

    always #5 clk = ~clk;

    // One microsecond per clock keeps runs short; registered RAM read port.
    always @(posedge clk) begin
        timeUs <= timerReset ? '0 : timeUs + TW'(1);
        memReadData <= ram[memReadAddress];
    end

    always @(negedge clk) begin
        if (noteActive && !prevActive) begin
            obsRise.push_back(int'(timeUs));
            obsPitch.push_back(int'(notePitch));
            obsIdx.push_back(int'(noteIndex));
        end
        if (!noteActive && prevActive) obsFall.push_back(int'(timeUs));
        if (donePulse) obsDone.push_back(int'(timeUs));
        if (timerReset) trCount++;
        if (timerReset && prevTr) trLong++;
        if (timerReset) seenNz = 0;
        else if (busy && memReadAddress != 0) seenNz = 1;
        else if (busy && seenNz) wraps++;
        prevActive = noteActive;
        prevTr = timerReset;
    end

    function automatic logic [RW-1:0] mkRec(input int p, input int s, input int e);
        return {PW'(p), TW'(s), TW'(e)};
    endfunction

    // Timeline model: f is the timer value seen during a record's FETCH cycle.
    function automatic void model();
        int f, s, e, w, rise, fall;
        logic [RW-1:0] r;
        expRise.delete(); expFall.delete(); expPitch.delete(); expIdx.delete();
        expDone = -1;
        f = 0;
        for (int a = 0; a < DEPTH; a++) begin
            r = ram[a];
            if (r == '0) begin
                expDone = f + 2;
                return;
            end
            s = int'(r[2*TW-1 -: TW]);
            e = int'(r[TW-1:0]);
            if (e <= s) begin
                f = f + 2;
                if (a == DEPTH - 1) expDone = f;
                continue;
            end
            w = (s > f + 2) ? s : f + 2;
            rise = w + 1;
            fall = ((e > rise) ? e : rise) + 1;
            expRise.push_back(rise);
            expFall.push_back(fall);
            expPitch.push_back(int'(r[RW-1 -: PW]));
            expIdx.push_back(a);
            f = fall;
            if (a == DEPTH - 1) expDone = fall;
        end
    endfunction

    task automatic begin_run();
        obsRise.delete(); obsFall.delete(); obsPitch.delete(); obsIdx.delete(); obsDone.delete();
        trCount = 0; trLong = 0; wraps = 0;
        @(posedge clk); #1 startPlayback = 1;
        @(posedge clk); #1 startPlayback = 0;
    endtask

    task automatic play(output bit timedOut);
        begin_run();
        timedOut = 1;
        for (int i = 0; i < 12000; i++) begin
            @(negedge clk);
            if (obsDone.size() > 0) begin
                timedOut = 0;
                break;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({noteActive, busy, donePulse, timerReset} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, expected 0000", {noteActive, busy, donePulse, timerReset});
        end
        checks++;
        if ({memReadAddress, notePitch, noteIndex} !== '0) begin
            errors++;
            $display("FAIL reset_values: addr %0d pitch %0d index %0d, expected all 0", memReadAddress, notePitch, noteIndex);
        end
        repeat (2) @(negedge clk);
        reset = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || noteActive !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy %b active %b, expected 0 0", busy, noteActive);
        end
    endtask

    task automatic test_single_note();
        bit to;
        ram[0] = mkRec(7, 1000, 5000); ram[1] = '0;
        play(to);
        checks++;
        if (to || trCount != 1 || trLong != 0) begin
            errors++;
            $display("FAIL single_timer_reset: timeout %0b pulses %0d long %0d, expected 0 1 0", to, trCount, trLong);
        end
        checks++;
        if (obsRise.size() != 1 || obsRise[0] != 1001 || obsPitch[0] != 7 || obsIdx[0] != 0) begin
            errors++;
            $display("FAIL single_rise: rises %0d at %0d pitch %0d idx %0d, expected 1 at 1001 pitch 7 idx 0",
                     obsRise.size(), obsRise.size() ? obsRise[0] : -1, obsPitch.size() ? obsPitch[0] : -1, obsIdx.size() ? obsIdx[0] : -1);
        end
        checks++;
        if (obsFall.size() != 1 || obsFall[0] != 5001) begin
            errors++;
            $display("FAIL single_fall: falls %0d at %0d, expected 1 at 5001", obsFall.size(), obsFall.size() ? obsFall[0] : -1);
        end
        checks++;
        if (obsDone.size() != 1 || obsDone[0] != 5003 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done: pulses %0d at %0d busy %b, expected 1 at 5003 busy 0",
                     obsDone.size(), obsDone.size() ? obsDone[0] : -1, busy);
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        ram[0] = mkRec(3, 0, 100); ram[1] = mkRec(4, 100, 200); ram[2] = '0;
        play(to);
        checks++;
        if (to || obsRise.size() != 2 || obsFall.size() != 2) begin
            errors++;
            $display("FAIL b2b_count: timeout %0b rises %0d falls %0d, expected 0 2 2", to, obsRise.size(), obsFall.size());
        end else begin
            checks++;
            if (obsPitch[0] != 3 || obsPitch[1] != 4 || obsIdx[0] != 0 || obsIdx[1] != 1) begin
                errors++;
                $display("FAIL b2b_pitch_index: pitches %0d,%0d idx %0d,%0d, expected 3,4 idx 0,1",
                         obsPitch[0], obsPitch[1], obsIdx[0], obsIdx[1]);
            end
            checks++;
            if (obsRise[1] - obsFall[0] != 3 || obsRise[0] != 3 || obsFall[1] != 201) begin
                errors++;
                $display("FAIL b2b_gap: gap %0d rise0 %0d fall1 %0d, expected gap 3 rise0 3 fall1 201",
                         obsRise[1] - obsFall[0], obsRise[0], obsFall[1]);
            end
        end
    endtask

    task automatic test_malformed();
        bit to;
        ram[0] = mkRec(5, 300, 300); ram[1] = mkRec(6, 400, 500); ram[2] = '0;
        play(to);
        checks++;
        if (to || obsRise.size() != 1 || obsPitch[0] != 6 || obsIdx[0] != 1 || obsRise[0] != 401 ||
            obsFall.size() != 1 || obsFall[0] != 501) begin
            errors++;
            $display("FAIL malformed_skip: timeout %0b rises %0d pitch %0d idx %0d rise %0d fall %0d, expected 1 note pitch 6 idx 1 401..501",
                     to, obsRise.size(), obsPitch.size() ? obsPitch[0] : -1, obsIdx.size() ? obsIdx[0] : -1,
                     obsRise.size() ? obsRise[0] : -1, obsFall.size() ? obsFall[0] : -1);
        end
    endtask

    task automatic test_stop();
        bit found = 0, to;
        ram[0] = mkRec(2, 1000, 5000); ram[1] = '0;
        begin_run();
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            found = timeUs == 2000;
        end
        checks++;
        if (!found || noteActive !== 1'b1) begin
            errors++;
            $display("FAIL stop_reach_playing: found %0b active %b, expected 1 1", found, noteActive);
        end
        stopPlayback = 1;
        @(posedge clk); #1 stopPlayback = 0;
        @(negedge clk);
        checks++;
        if (noteActive !== 1'b0 || busy !== 1'b0 || memReadAddress !== '0) begin
            errors++;
            $display("FAIL stop_abort: active %b busy %b addr %0d, expected 0 0 0", noteActive, busy, memReadAddress);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (obsDone.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_no_done: pulses %0d busy %b, expected 0 0", obsDone.size(), busy);
        end
        play(to);
        checks++;
        if (to || trCount != 1 || obsRise.size() != 1 || obsRise[0] != 1001 || obsIdx[0] != 0) begin
            errors++;
            $display("FAIL stop_replay: timeout %0b pulses %0d rises %0d at %0d, expected 0 1 1 at 1001",
                     to, trCount, obsRise.size(), obsRise.size() ? obsRise[0] : -1);
        end
    endtask

    task automatic test_start_stop_same();
        ram[0] = mkRec(2, 1000, 5000); ram[1] = '0;
        begin_run();
        repeat (10) @(negedge clk);
        trCount = 0;
        startPlayback = 1; stopPlayback = 1;
        @(posedge clk); #1 startPlayback = 0; stopPlayback = 0;
        repeat (5) @(negedge clk);
        checks++;
        if (trCount != 0 || busy !== 1'b0 || noteActive !== 1'b0) begin
            errors++;
            $display("FAIL start_stop_same: timer pulses %0d busy %b active %b, expected 0 0 0", trCount, busy, noteActive);
        end
    endtask

    task automatic test_full_ram();
        bit to;
        int er[4] = '{11, 31, 51, 71};
        int ef[4] = '{21, 41, 61, 81};
        for (int a = 0; a < DEPTH; a++) ram[a] = mkRec(a + 1, 10 + 20*a, 20 + 20*a);
        play(to);
        checks++;
        if (to || obsRise.size() != 4 || obsFall.size() != 4 || obsDone.size() != 1 || obsDone[0] != 81 || wraps != 0) begin
            errors++;
            $display("FAIL full_ram_run: timeout %0b rises %0d falls %0d dones %0d wraps %0d, expected 0 4 4 1 0",
                     to, obsRise.size(), obsFall.size(), obsDone.size(), wraps);
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (obsRise[k] != er[k] || obsFall[k] != ef[k] || obsIdx[k] != k || obsPitch[k] != k + 1) begin
                    errors++;
                    $display("FAIL full_ram_note%0d: %0d..%0d idx %0d pitch %0d, expected %0d..%0d idx %0d pitch %0d",
                             k, obsRise[k], obsFall[k], obsIdx[k], obsPitch[k], er[k], ef[k], k, k + 1);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        bit found = 0;
        ram[0] = mkRec(9, 10, 1000); ram[1] = '0;
        begin_run();
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            found = noteActive === 1'b1;
        end
        #2 reset = 1;
        #1;
        checks++;
        if (!found || noteActive !== 1'b0 || busy !== 1'b0 || notePitch !== '0) begin
            errors++;
            $display("FAIL async_reset: found %0b active %b busy %b pitch %0d, expected 1 0 0 0", found, noteActive, busy, notePitch);
        end
        @(negedge clk);
        reset = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        bit to;
        for (int it = 0; it < 30; it++) begin
            int prevEnd = 0;
            for (int a = 0; a < DEPTH; a++) begin
                int kind = int'($urandom_range(0, 9));
                int p = int'($urandom_range(0, 31));
                int s = ($urandom_range(0, 2) == 0) ? prevEnd : prevEnd + int'($urandom_range(0, 150));
                int e;
                if (kind == 0) ram[a] = '0;
                else if (kind < 3) begin
                    e = s - int'($urandom_range(0, s > 20 ? 20 : s));
                    ram[a] = mkRec(p, s, e);
                end else begin
                    e = s + int'($urandom_range(1, 150));
                    ram[a] = mkRec(p, s, e);
                    prevEnd = e;
                end
            end
            model();
            play(to);
            checks++;
            if (to || obsRise.size() != expRise.size() || obsFall.size() != expFall.size() || obsDone.size() != 1) begin
                errors++;
                $display("FAIL random%0d_counts: timeout %0b rises %0d falls %0d dones %0d, expected 0 %0d %0d 1",
                         it, to, obsRise.size(), obsFall.size(), obsDone.size(), expRise.size(), expFall.size());
            end else begin
                for (int k = 0; k < expRise.size(); k++) begin
                    checks++;
                    if (obsRise[k] != expRise[k] || obsFall[k] != expFall[k] || obsPitch[k] != expPitch[k] || obsIdx[k] != expIdx[k]) begin
                        errors++;
                        $display("FAIL random%0d_note%0d: %0d..%0d pitch %0d idx %0d, expected %0d..%0d pitch %0d idx %0d",
                                 it, k, obsRise[k], obsFall[k], obsPitch[k], obsIdx[k], expRise[k], expFall[k], expPitch[k], expIdx[k]);
                    end
                end
                checks++;
                if (obsDone[0] != expDone || trCount != 1 || trLong != 0 || wraps != 0) begin
                    errors++;
                    $display("FAIL random%0d_done: at %0d pulses %0d long %0d wraps %0d, expected at %0d 1 0 0",
                             it, obsDone[0], trCount, trLong, wraps, expDone);
                end
            end
        end
    endtask

    initial begin
        for (int a = 0; a < DEPTH; a++) ram[a] = '0;
        test_reset();
        test_single_note();
        test_back_to_back();
        test_malformed();
        test_stop();
        test_start_stop_same();
        test_full_ram();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
